// File: rtl/alu_seq_param.sv
// Sequential ALU with valid/ready handshakes and an iterative shift-add multiplier.
// Operands are captured at accept; results and flags are held until the consumer takes them.
module alu_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t               state, state_nxt;
    logic                 accept;
    logic                 last;
    logic [SHW-1:0]       cnt;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   prod_nxt;
    logic [WIDTH:0]       psum;
    logic [WIDTH:0]       wide;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;

    assign accept = in_valid & in_ready;
    assign last   = (cnt == SHW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid)
                      state_nxt = (op == OP_MUL) ? EXEC : DONE;
            EXEC: if (last)
                      state_nxt = DONE;
            DONE: if (out_ready)
                      state_nxt = !in_valid ? IDLE :
                                  (op == OP_MUL) ? EXEC : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
        out_valid = (state == DONE);
    end

    // Single-cycle ops; shifts run one bit wide so the carry is the last bit out.
    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op)
            OP_ADD: begin
                wide    = {1'b0, a} + {1'b0, b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &
                          (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                wide    = {1'b0, a} - {1'b0, b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &
                          (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                wide    = {1'b0, a} << b[SHW-1:0];
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_SHR: begin
                wide    = {a, 1'b0} >> b[SHW-1:0];
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            default: ;
        endcase
    end

    // One partial product per cycle; multiplier shifts out of the low half.
    always_comb begin
        psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                   (prod[0] ? {1'b0, mcand} : '0);
        prod_nxt = {psum, prod[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mcand     <= '0;
            prod      <= '0;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
        end else if (accept) begin
            cnt   <= '0;
            mcand <= a;
            prod  <= {{WIDTH{1'b0}}, b};
            if (op != OP_MUL) begin
                result    <= alu_res;
                result_hi <= '0;
                flags     <= {alu_res == '0, alu_res[WIDTH-1],
                              alu_c, alu_v};
            end
        end else if (state == EXEC) begin
            cnt  <= cnt + 1'b1;
            prod <= prod_nxt;
            if (last) begin
                result    <= prod_nxt[WIDTH-1:0];
                result_hi <= prod_nxt[2*WIDTH-1:WIDTH];
                flags     <= {prod_nxt == '0, prod_nxt[2*WIDTH-1],
                              |prod_nxt[2*WIDTH-1:WIDTH], 1'b0};
            end
        end
    end
endmodule
